// File: rtl/multi_acc_if.sv
// Product-in / frame-sum-out bus for multi_acc.
// The max_out signal exists only when MULTI_ACC_MAX_EN is defined.
interface multi_acc_if #(
   parameter int ACC_W = 20,
   parameter int CNT_W = 4
);
   logic [15:0]      p_in;
   logic             p_valid;
   logic             p_ready;
   logic [CNT_W-1:0] len;
   logic [ACC_W-1:0] acc_out;
   logic             o_valid;
   logic             o_ready;
`ifdef MULTI_ACC_MAX_EN
   logic [15:0]      max_out;

   modport master (
      output p_in, p_valid, len, o_ready,
      input  p_ready, acc_out, o_valid, max_out
   );

   modport slave (
      input  p_in, p_valid, len, o_ready,
      output p_ready, acc_out, o_valid, max_out
   );
`else
   modport master (
      output p_in, p_valid, len, o_ready,
      input  p_ready, acc_out, o_valid
   );

   modport slave (
      input  p_in, p_valid, len, o_ready,
      output p_ready, acc_out, o_valid
   );
`endif
endinterface

// File: rtl/multi_acc.sv
// Frame accumulator: sums 1..2^CNT_W unsigned 16-bit products per frame.
// Optional frame-maximum output is enabled by defining MULTI_ACC_MAX_EN.
module multi_acc #(
   parameter int ACC_W = 20,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   multi_acc_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W:0]   cnt;
   logic [CNT_W:0]   frame_len;
   logic [ACC_W-1:0] acc_out_r;
   logic             o_valid_r;
   logic             p_ready_r;

   logic [ACC_W-1:0] p_ext;
   logic [ACC_W-1:0] sum_nxt;
   logic [CNT_W:0]   cnt_nxt;
   logic [CNT_W:0]   len_dec;
   logic             accept;

   // A len field of zero stands for the largest frame, 2^CNT_W products.
   function automatic logic [CNT_W:0] decode_len(input logic [CNT_W-1:0] l);
      if (l == '0) begin
         decode_len = {1'b1, {CNT_W{1'b0}}};
      end else begin
         decode_len = {1'b0, l};
      end
   endfunction

   function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
      max16 = (b > a) ? b : a;
   endfunction

   assign p_ext   = {{(ACC_W-16){1'b0}}, bus.p_in};
   assign sum_nxt = acc + p_ext;
   assign cnt_nxt = cnt + {{CNT_W{1'b0}}, 1'b1};
   assign len_dec = decode_len(bus.len);
   assign accept  = bus.p_valid && p_ready_r;

   assign bus.p_ready = p_ready_r;
   assign bus.o_valid = o_valid_r;
   assign bus.acc_out = acc_out_r;

`ifdef MULTI_ACC_MAX_EN
   logic [15:0] max_r;
   assign bus.max_out = max_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         max_r <= '0;
      end else if (accept) begin
         max_r <= (state == IDLE) ? bus.p_in : max16(max_r, bus.p_in);
      end
   end
`endif

   // Control and datapath share one FSM so the result registers and flags
   // change on exactly the edge that accepts the frame's last product.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         frame_len <= '0;
         acc_out_r <= '0;
         o_valid_r <= 1'b0;
         p_ready_r <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc       <= p_ext;
                  cnt       <= {{CNT_W{1'b0}}, 1'b1};
                  frame_len <= len_dec;
                  if (len_dec == {{CNT_W{1'b0}}, 1'b1}) begin
                     state     <= DONE;
                     acc_out_r <= p_ext;
                     o_valid_r <= 1'b1;
                     p_ready_r <= 1'b0;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  acc <= sum_nxt;
                  cnt <= cnt_nxt;
                  if (cnt_nxt == frame_len) begin
                     state     <= DONE;
                     acc_out_r <= sum_nxt;
                     o_valid_r <= 1'b1;
                     p_ready_r <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (bus.o_ready) begin
                  state     <= IDLE;
                  o_valid_r <= 1'b0;
                  p_ready_r <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               o_valid_r <= 1'b0;
               p_ready_r <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_acc.sv
// Scoreboard bench for multi_acc: directed frames push expected sums,
// a monitor pops and compares on every output handshake.
module tb_multi_acc;
   localparam int ACC_W = 20;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [ACC_W-1:0] acc;
      logic [15:0]      mx;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   multi_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus();

   multi_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic expect_frame(input logic [ACC_W-1:0] a, input logic [15:0] m);
      exp_t e;
      e.acc = a;
      e.mx  = m;
      sb.push_back(e);
   endtask

   // Present one product until accepted; returns the number of edges waited.
   task automatic put(input logic [15:0] p, input logic [CNT_W-1:0] l, output int waits);
      logic taken;
      taken = 1'b0;
      waits = 0;
      bus.p_in    = p;
      bus.len     = l;
      bus.p_valid = 1'b1;
      while (!taken && waits < 50) begin
         @(negedge clk);
         taken = bus.p_ready;
         @(posedge clk);
         #1;
         waits++;
      end
      bus.p_valid = 1'b0;
      check("accept_timeout", taken, 1);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.o_valid && bus.o_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", bus.acc_out, 0);
            checks++;
            errors++;
            $display("FAIL unexpected_output: got acc_out %0d with empty scoreboard", bus.acc_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("acc_out", bus.acc_out, e.acc);
`ifdef MULTI_ACC_MAX_EN
            check("max_out", bus.max_out, e.mx);
`endif
         end
      end
   end

   initial begin
      int w;
      bus.p_in    = '0;
      bus.p_valid = 1'b0;
      bus.len     = '0;
      bus.o_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_p_ready", bus.p_ready, 1);
      check("rst_acc_out", bus.acc_out, 0);
`ifdef MULTI_ACC_MAX_EN
      check("rst_max_out", bus.max_out, 0);
`endif
      @(posedge clk);
      #1;

      // Four-product frame, o_valid on the last accept edge
      expect_frame(2065, 2048);
      put(1, 4, w);
      put(12, 4, w);
      put(4, 4, w);
      check("len4_not_early", bus.o_valid, 0);
      put(2048, 4, w);
      check("len4_o_valid_latency", bus.o_valid, 1);
      @(posedge clk);
      #1;

      // Single-product frame under back-pressure
      bus.o_ready = 1'b0;
      expect_frame(12, 12);
      put(12, 1, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_o_valid", bus.o_valid, 1);
         check("bp_p_ready", bus.p_ready, 0);
         check("bp_acc_out", bus.acc_out, 12);
         @(posedge clk);
         #1;
      end
      bus.o_ready = 1'b1;
      @(posedge clk);
      #1;

      // Full-length frame of maximum products
      expect_frame(1040400, 65025);
      for (int i = 0; i < 16; i++) put(16'd65025, 0, w);
      @(posedge clk);
      #1;

      // Gap with p_valid low and len changed mid-frame
      expect_frame(21, 9);
      put(5, 3, w);
      bus.len = 1;
      repeat (2) @(posedge clk);
      #1;
      check("gap_o_valid", bus.o_valid, 0);
      check("gap_p_ready", bus.p_ready, 1);
      put(7, 1, w);
      check("gap_len_ignored", bus.o_valid, 0);
      put(9, 1, w);
      @(posedge clk);
      #1;

      // Reset aborts a partial frame
      put(100, 4, w);
      put(200, 4, w);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_acc_out", bus.acc_out, 0);
      check("abort_p_ready", bus.p_ready, 1);
      expect_frame(12, 3);
      for (int i = 0; i < 4; i++) put(3, 4, w);
      @(posedge clk);
      #1;

      // Back-to-back frames: next first product waits out the DONE cycle
      expect_frame(30, 20);
      expect_frame(7, 7);
      put(10, 2, w);
      put(20, 2, w);
      check("b2b_first_waits", w, 1);
      put(7, 1, w);
      check("b2b_done_stall", w, 2);
      @(posedge clk);
      #1;

      // Reset in DONE drops the pending result
      bus.o_ready = 1'b0;
      put(55, 1, w);
      check("drop_o_valid_before", bus.o_valid, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("drop_o_valid_after", bus.o_valid, 0);
      check("drop_p_ready_after", bus.p_ready, 1);
      bus.o_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
